// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 pipeline control slice.
// Holds the status codes carried down the pipe, the instruction codes the
// hazard logic cares about, the "no register" ID and the control FSM states.
package y86_pkg;

    // Status codes travelling with each instruction
    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    // Instruction codes (icode field)
    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    // Register ID meaning "no register"
    localparam logic [3:0] REG_NONE = 4'hF;

    // Pipeline control FSM states
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED,
        ST_FAULT
    } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter used for the pipeline performance counters.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, clears the count
//   inc    - increment request for this cycle
//   en     - counting enable (only while the pipeline is running)
//   count  - current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count up when enabled and requested, but hold once the all-ones value
    // is reached so long runs report "at least this many" rather than wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: control unit for the five-stage Y86-64 pipeline.
// Produces stall/bubble controls for the F, D, E, M and W pipeline registers
// from load-use, return, mispredict and exception hazards, sequences the boot
// flush / halt / fault shutdown through a small FSM, and keeps saturating
// performance counters.
// Ports:
//   clock, reset                 - clock and asynchronous active-high reset
//   D_in_code, d_src_a, d_src_b  - decode-stage icode and source register IDs
//   E_in_code, E_dst_m, e_cnd    - execute-stage icode, load destination, branch condition
//   M_in_code, m_stat            - memory-stage icode and status it produces
//   W_in_code, W_stat            - writeback-stage icode and status
//   F_st, D_st, W_st             - stall controls
//   D_bub, E_bub, M_bub          - bubble controls
//   set_cc_en                    - execute may update condition codes
//   halted, fault                - terminal state indicators
//   cyc_cnt, ret_cnt, stall_cnt, bub_cnt - performance counters
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       D_in_code,
    input  logic [3:0]       d_src_a,
    input  logic [3:0]       d_src_b,
    input  logic [3:0]       E_in_code,
    input  logic [3:0]       E_dst_m,
    input  logic             e_cnd,
    input  logic [3:0]       M_in_code,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_in_code,
    input  logic [1:0]       W_stat,
    output logic             F_st,
    output logic             D_st,
    output logic             D_bub,
    output logic             E_bub,
    output logic             M_bub,
    output logic             W_st,
    output logic             set_cc_en,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bub_cnt
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    ctrl_state_t state, state_next;
    logic [BW-1:0] boot_cnt, boot_cnt_next;

    logic lu, rt, mp, exc;
    logic run_en, ret_inc, bub_inc;

    // Hazard detection terms, purely combinational from the stage registers.
    // lu: a load in E writes a register that decode is reading right now.
    // rt: a ret somewhere in D/E/M, so the fetch PC is not yet known.
    // mp: a conditional jump in E was predicted taken but is not taken.
    // exc: an exceptional status is in flight in M or W.
    always_comb begin
        lu  = ((E_in_code == I_MRMOVQ) || (E_in_code == I_POPQ)) &&
              (E_dst_m != REG_NONE) &&
              ((E_dst_m == d_src_a) || (E_dst_m == d_src_b));
        rt  = (D_in_code == I_RET) || (E_in_code == I_RET) || (M_in_code == I_RET);
        mp  = (E_in_code == I_JXX) && !e_cnd;
        exc = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
    end

    // State register and boot countdown. Reset drops straight into BOOT with
    // the countdown primed so the flush lasts exactly BOOT_CYCLES cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_BOOT;
            boot_cnt <= BW'(BOOT_CYCLES - 1);
        end else begin
            state    <= state_next;
            boot_cnt <= boot_cnt_next;
        end
    end

    // Next-state and pipeline control outputs. BOOT flushes D/E/M with bubbles
    // because the stage registers carry no reset; RUN resolves hazards; HALTED
    // and FAULT freeze fetch/decode/writeback and keep injecting bubbles so no
    // further architectural state changes until the next reset.
    always_comb begin
        state_next    = state;
        boot_cnt_next = boot_cnt;
        F_st          = 1'b0;
        D_st          = 1'b0;
        D_bub         = 1'b0;
        E_bub         = 1'b0;
        M_bub         = 1'b0;
        W_st          = 1'b0;
        set_cc_en     = 1'b0;
        case (state)
            ST_BOOT: begin
                D_bub = 1'b1;
                E_bub = 1'b1;
                M_bub = 1'b1;
                if (boot_cnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    boot_cnt_next = boot_cnt - BW'(1);
                end
            end
            ST_RUN: begin
                F_st      = lu | rt;
                D_st      = lu;
                D_bub     = mp | (rt & !lu);
                E_bub     = mp | lu;
                M_bub     = exc;
                W_st      = (W_stat != STAT_AOK);
                set_cc_en = !exc;
                if (W_stat == STAT_HLT) begin
                    state_next = ST_HALTED;
                end else if ((W_stat == STAT_ADR) || (W_stat == STAT_INS)) begin
                    state_next = ST_FAULT;
                end
            end
            ST_HALTED, ST_FAULT: begin
                F_st  = 1'b1;
                D_st  = 1'b1;
                W_st  = 1'b1;
                E_bub = 1'b1;
                M_bub = 1'b1;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Status flags and counter increment conditions. Counters only move in
    // RUN, so they stay at zero through boot and freeze once terminal.
    always_comb begin
        halted  = (state == ST_HALTED);
        fault   = (state == ST_FAULT);
        run_en  = (state == ST_RUN);
        ret_inc = (W_stat == STAT_AOK) && (W_in_code != I_NOP) && !W_st;
        bub_inc = D_bub | E_bub;
    end

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (1'b1),
        .en    (run_en),
        .count (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (ret_inc),
        .en    (run_en),
        .count (ret_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (F_st),
        .en    (run_en),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bub_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (bub_inc),
        .en    (run_en),
        .count (bub_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Drives directed hazard scenarios followed
// by randomized episodes into two instances (32-bit and 4-bit counters) that
// share all inputs, and compares both against a behavioural model every cycle.
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  D_in_code, d_src_a, d_src_b, E_in_code, E_dst_m, M_in_code, W_in_code;
    logic        e_cnd;
    logic [1:0]  m_stat, W_stat;

    logic        F_st, D_st, D_bub, E_bub, M_bub, W_st, set_cc_en, halted, fault;
    logic [31:0] cyc_cnt, ret_cnt, stall_cnt, bub_cnt;

    logic        F_st4, D_st4, D_bub4, E_bub4, M_bub4, W_st4, set_cc_en4, halted4, fault4;
    logic [3:0]  cyc_cnt4, ret_cnt4, stall_cnt4, bub_cnt4;

    int nChecks = 0;
    int nFails  = 0;

    // Model: mode 0 = boot, 1 = run, 2 = halted, 3 = fault
    int     mMode;
    int     mBootLeft;
    longint mCyc, mRet, mStall, mBub;

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .D_in_code(D_in_code), .d_src_a(d_src_a), .d_src_b(d_src_b),
        .E_in_code(E_in_code), .E_dst_m(E_dst_m), .e_cnd(e_cnd),
        .M_in_code(M_in_code), .m_stat(m_stat),
        .W_in_code(W_in_code), .W_stat(W_stat),
        .F_st(F_st), .D_st(D_st), .D_bub(D_bub), .E_bub(E_bub), .M_bub(M_bub),
        .W_st(W_st), .set_cc_en(set_cc_en), .halted(halted), .fault(fault),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .bub_cnt(bub_cnt)
    );

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset),
        .D_in_code(D_in_code), .d_src_a(d_src_a), .d_src_b(d_src_b),
        .E_in_code(E_in_code), .E_dst_m(E_dst_m), .e_cnd(e_cnd),
        .M_in_code(M_in_code), .m_stat(m_stat),
        .W_in_code(W_in_code), .W_stat(W_stat),
        .F_st(F_st4), .D_st(D_st4), .D_bub(D_bub4), .E_bub(E_bub4), .M_bub(M_bub4),
        .W_st(W_st4), .set_cc_en(set_cc_en4), .halted(halted4), .fault(fault4),
        .cyc_cnt(cyc_cnt4), .ret_cnt(ret_cnt4), .stall_cnt(stall_cnt4), .bub_cnt(bub_cnt4)
    );

    always #5 clock = ~clock;

    // Single comparison point: every check counts and reports through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] dIc, input logic [3:0] srcA, input logic [3:0] srcB,
                                 input logic [3:0] eIc, input logic [3:0] eDst, input logic eCnd,
                                 input logic [3:0] mIc, input logic [1:0] mSt,
                                 input logic [3:0] wIc, input logic [1:0] wSt);
        D_in_code = dIc; d_src_a = srcA; d_src_b = srcB;
        E_in_code = eIc; E_dst_m = eDst; e_cnd = eCnd;
        M_in_code = mIc; m_stat = mSt;
        W_in_code = wIc; W_stat = wSt;
    endtask

    task automatic applyQuiet();
        applyStimulus(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 2'd0, 4'd1, 2'd0);
    endtask

    task automatic applyRandom();
        logic [3:0] ms, ws;
        D_in_code = 4'($urandom_range(0, 11));
        E_in_code = 4'($urandom_range(0, 11));
        M_in_code = 4'($urandom_range(0, 11));
        W_in_code = 4'($urandom_range(0, 11));
        d_src_a   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
        d_src_b   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
        E_dst_m   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
        e_cnd     = 1'($urandom_range(0, 1));
        ms        = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
        ws        = ($urandom_range(0, 79) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
        m_stat    = ms[1:0];
        W_stat    = ws[1:0];
    endtask

    task automatic waitCycle();
        @(posedge clock);
        #1;
    endtask

    function automatic longint satv(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Expected control outputs from the hazard rules and the model mode.
    function automatic void expOut(output logic eF, output logic eDs, output logic eDb,
                                   output logic eEb, output logic eMb, output logic eWs,
                                   output logic eCc, output logic luMp);
        bit lu, rt, mp, exc;
        lu  = (E_in_code == 4'd5 || E_in_code == 4'd11) && E_dst_m != 4'd15 &&
              (E_dst_m == d_src_a || E_dst_m == d_src_b);
        rt  = (D_in_code == 4'd9) || (E_in_code == 4'd9) || (M_in_code == 4'd9);
        mp  = (E_in_code == 4'd7) && !e_cnd;
        exc = (m_stat != 2'd0) || (W_stat != 2'd0);
        luMp = 1'b0;
        if (mMode == 0) begin
            eF = 0; eDs = 0; eDb = 1; eEb = 1; eMb = 1; eWs = 0; eCc = 0;
        end else if (mMode == 1) begin
            eF = lu | rt; eDs = lu; eDb = mp | (rt & !lu); eEb = mp | lu;
            eMb = exc; eWs = (W_stat != 2'd0); eCc = !exc;
            luMp = lu & mp;
        end else begin
            eF = 1; eDs = 1; eDb = 0; eEb = 1; eMb = 1; eWs = 1; eCc = 0;
        end
    endfunction

    // Behavioural model: boot countdown, run bookkeeping, terminal modes.
    always @(posedge clock or posedge reset) begin
        logic xF, xDs, xDb, xEb, xMb, xWs, xCc, xLm;
        if (reset) begin
            mMode = 0; mBootLeft = 2;
            mCyc = 0; mRet = 0; mStall = 0; mBub = 0;
        end else if (mMode == 0) begin
            mBootLeft = mBootLeft - 1;
            if (mBootLeft == 0) mMode = 1;
        end else if (mMode == 1) begin
            expOut(xF, xDs, xDb, xEb, xMb, xWs, xCc, xLm);
            mCyc++;
            if (W_stat == 2'd0 && W_in_code != 4'd1 && !xWs) mRet++;
            if (xF) mStall++;
            if (xDb | xEb) mBub++;
            if (W_stat == 2'd1) mMode = 2;
            else if (W_stat != 2'd0) mMode = 3;
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clock) begin
        logic cF, cDs, cDb, cEb, cMb, cWs, cCc, cLm;
        expOut(cF, cDs, cDb, cEb, cMb, cWs, cCc, cLm);
        checkOutput("F_st", F_st, cF);
        if (!cLm) checkOutput("D_st", D_st, cDs);
        checkOutput("D_bub", D_bub, cDb);
        checkOutput("E_bub", E_bub, cEb);
        checkOutput("M_bub", M_bub, cMb);
        checkOutput("W_st", W_st, cWs);
        checkOutput("set_cc_en", set_cc_en, cCc);
        checkOutput("halted", halted, mMode == 2);
        checkOutput("fault", fault, mMode == 3);
        checkOutput("cyc_cnt", cyc_cnt, satv(mCyc, 32));
        checkOutput("ret_cnt", ret_cnt, satv(mRet, 32));
        checkOutput("stall_cnt", stall_cnt, satv(mStall, 32));
        checkOutput("bub_cnt", bub_cnt, satv(mBub, 32));
        checkOutput("cyc_cnt4", cyc_cnt4, satv(mCyc, 4));
        checkOutput("ret_cnt4", ret_cnt4, satv(mRet, 4));
        checkOutput("stall_cnt4", stall_cnt4, satv(mStall, 4));
        checkOutput("bub_cnt4", bub_cnt4, satv(mBub, 4));
    end

    // Time limit so the run always ends on its own.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios with literal expectations, then random episodes.
    initial begin
        int term;
        applyQuiet();
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("rst D_bub", D_bub, 1);
        checkOutput("rst E_bub", E_bub, 1);
        checkOutput("rst M_bub", M_bub, 1);
        checkOutput("rst F_st", F_st, 0);
        checkOutput("rst cyc_cnt", cyc_cnt, 0);
        checkOutput("rst halted", halted, 0);

        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        checkOutput("boot1 D_bub", D_bub, 1);
        waitCycle();
        @(negedge clock);
        checkOutput("boot2 D_bub", D_bub, 1);
        waitCycle();
        @(negedge clock);
        checkOutput("run D_bub", D_bub, 0);
        checkOutput("run E_bub", E_bub, 0);
        checkOutput("run M_bub", M_bub, 0);
        checkOutput("run F_st", F_st, 0);
        checkOutput("run cyc_cnt", cyc_cnt, 0);

        // Load-use on source A
        waitCycle();
        applyStimulus(4'd6, 4'd3, 4'd15, 4'd5, 4'd3, 1'b1, 4'd1, 2'd0, 4'd1, 2'd0);
        @(negedge clock);
        checkOutput("lu F_st", F_st, 1);
        checkOutput("lu D_st", D_st, 1);
        checkOutput("lu E_bub", E_bub, 1);
        checkOutput("lu D_bub", D_bub, 0);
        waitCycle();
        applyQuiet();
        @(negedge clock);
        checkOutput("lu stall_cnt", stall_cnt, 1);
        checkOutput("lu bub_cnt", bub_cnt, 1);
        checkOutput("lu cyc_cnt", cyc_cnt, 2);

        // Mispredicted branch
        waitCycle();
        applyStimulus(4'd6, 4'd15, 4'd15, 4'd7, 4'd15, 1'b0, 4'd1, 2'd0, 4'd1, 2'd0);
        @(negedge clock);
        checkOutput("mp D_bub", D_bub, 1);
        checkOutput("mp E_bub", E_bub, 1);
        checkOutput("mp F_st", F_st, 0);

        // Load-use together with ret in decode
        waitCycle();
        applyStimulus(4'd9, 4'd3, 4'd15, 4'd5, 4'd3, 1'b1, 4'd1, 2'd0, 4'd1, 2'd0);
        @(negedge clock);
        checkOutput("lu+ret D_st", D_st, 1);
        checkOutput("lu+ret D_bub", D_bub, 0);

        // Ret in memory, no load-use
        waitCycle();
        applyStimulus(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd9, 2'd0, 4'd1, 2'd0);
        @(negedge clock);
        checkOutput("retM F_st", F_st, 1);
        checkOutput("retM D_bub", D_bub, 1);

        // Ret sweeping through D, E, M
        for (int i = 0; i < 3; i++) begin
            waitCycle();
            applyStimulus((i == 0) ? 4'd9 : 4'd1, 4'd15, 4'd15, (i == 1) ? 4'd9 : 4'd1, 4'd15,
                          1'b1, (i == 2) ? 4'd9 : 4'd1, 2'd0, 4'd1, 2'd0);
            @(negedge clock);
            checkOutput("ret sweep D_bub", D_bub, 1);
        end

        // Memory-stage address fault
        waitCycle();
        applyStimulus(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd5, 2'd2, 4'd6, 2'd0);
        @(negedge clock);
        checkOutput("madr M_bub", M_bub, 1);
        checkOutput("madr set_cc_en", set_cc_en, 0);

        // Halt reaching writeback
        waitCycle();
        applyStimulus(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 2'd0, 4'd0, 2'd1);
        @(negedge clock);
        checkOutput("hlt W_st", W_st, 1);
        checkOutput("hlt pre halted", halted, 0);
        waitCycle();
        applyQuiet();
        @(negedge clock);
        checkOutput("halted", halted, 1);
        checkOutput("halted F_st", F_st, 1);
        checkOutput("halted D_st", D_st, 1);
        checkOutput("halted W_st", W_st, 1);
        checkOutput("halted D_bub", D_bub, 0);
        repeat (3) waitCycle();

        // Fresh boot, then an instruction fault
        reset = 1'b1;
        waitCycle();
        reset = 1'b0;
        repeat (3) waitCycle();
        applyStimulus(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 2'd0, 4'd6, 2'd3);
        waitCycle();
        applyQuiet();
        @(negedge clock);
        checkOutput("fault", fault, 1);
        checkOutput("fault halted", halted, 0);

        // Asynchronous reset in the middle of a cycle while faulted
        waitCycle();
        #2 reset = 1'b1;
        #1;
        checkOutput("async fault", fault, 0);
        checkOutput("async D_bub", D_bub, 1);
        checkOutput("async F_st", F_st, 0);
        checkOutput("async cyc_cnt", cyc_cnt, 0);

        // Saturation of the narrow counters
        waitCycle();
        reset = 1'b0;
        repeat (22) waitCycle();
        @(negedge clock);
        checkOutput("sat cyc_cnt32", cyc_cnt, 20);
        checkOutput("sat cyc_cnt4", cyc_cnt4, 15);

        // Randomized episodes, each ending a few cycles into a terminal state
        for (int ep = 0; ep < 10; ep++) begin
            waitCycle();
            reset = 1'b1;
            applyRandom();
            waitCycle();
            reset = 1'b0;
            term = 0;
            for (int c = 0; c < 400; c++) begin
                waitCycle();
                applyRandom();
                if (mMode >= 2) term++;
                if (term > 4) break;
            end
        end

        waitCycle();
        @(negedge clock);
        #1;
        $display("[TB] random episodes complete");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline.
- Generates the stall and bubble signals for the F, D, E, M and W pipeline registers from hazard conditions.
- Sequences boot flush, halt and fault shutdown through a small FSM, because the stage registers have no reset of their own.
- Keeps saturating performance counters for cycles, retirements, stalls and bubbles.

Parameters:
BOOT_CYCLES, 2, cycles of forced flush after reset release (>=1)
CNT_W, 32, width of each performance counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
D_in_code  in  4  icode in decode register
d_src_a  in  4  decode source A register ID (15 = none)
d_src_b  in  4  decode source B register ID (15 = none)
E_in_code  in  4  icode in execute register
E_dst_m  in  4  execute memory-destination register ID (15 = none)
e_cnd  in  1  execute condition result
M_in_code  in  4  icode in memory register
m_stat  in  2  status produced by memory stage
W_in_code  in  4  icode in writeback register
W_stat  in  2  status in writeback register
F_st  out  1  stall fetch (hold predicted PC)
D_st  out  1  stall decode register
D_bub  out  1  bubble decode register
E_bub  out  1  bubble execute register
M_bub  out  1  bubble memory register
W_st  out  1  stall writeback register
set_cc_en  out  1  permit execute to update condition codes
halted  out  1  high in HALTED state
fault  out  1  high in FAULT state
cyc_cnt  out  CNT_W  cycles spent in RUN
ret_cnt  out  CNT_W  instructions retired
stall_cnt  out  CNT_W  RUN cycles with F_st=1
bub_cnt  out  CNT_W  RUN cycles with D_bub or E_bub =1

Behaviour:
- Stat encoding: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- Icodes: 1 nop, 5 mrmovq, 7 jXX, 9 ret, 11 popq.
- FSM states: BOOT, RUN, HALTED, FAULT.
- Reset (async): state=BOOT, boot counter=BOOT_CYCLES-1, all counters 0, halted=fault=0.
- BOOT: D_bub=E_bub=M_bub=1, W_st=0, F_st=D_st=0, set_cc_en=0. Decrement each cycle; at 0 go to RUN. Total: BOOT_CYCLES cycles.
- RUN, combinational hazard terms:
  - lu = (E_in_code in {5,11}) && E_dst_m!=15 && (E_dst_m==d_src_a || E_dst_m==d_src_b)
  - rt = 9 in any of {D,E,M}_in_code
  - mp = E_in_code==7 && !e_cnd
  - exc = m_stat!=AOK || W_stat!=AOK
- RUN outputs:
  - F_st = lu | rt
  - D_st = lu
  - D_bub = mp | (rt & !lu)
  - E_bub = mp | lu
  - M_bub = exc
  - W_st = W_stat!=AOK
  - set_cc_en = !exc
- RUN transitions (registered, evaluated at clock edge):
  - W_stat==HLT -> HALTED
  - W_stat in {ADR,INS} -> FAULT
  - otherwise stay in RUN
- HALTED/FAULT:
  - F_st=D_st=W_st=1, D_bub=0, E_bub=M_bub=1, set_cc_en=0.
  - halted or fault =1. Terminal; left only by reset. Counters freeze.
- Simultaneous lu and mp: cannot occur with a legal jXX in E; if forced, E_bub=1, D_bub=1, D_st=1. D_bub takes priority in the stage register, so the bench checks only F_st, E_bub and D_bub.
- Counters, updated only in RUN:
  - cyc_cnt +1 every cycle.
  - ret_cnt +1 when W_stat==AOK && W_in_code!=1 && !W_st.
  - stall_cnt +1 when F_st.
  - bub_cnt +1 when D_bub|E_bub.
  - All saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-operation: outputs return to BOOT values immediately (async), regardless of state.
- All hazard outputs are combinational from inputs plus state; no added latency.

Decomposition:
- Shared package y86_pkg holds:
  - stat codes STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS
  - icode constants I_HALT..I_POPQ
  - REG_NONE=15
  - FSM state enum
- One sub-module: sat_counter (parameter CNT_W; inputs clock, reset, inc, en; output count), instantiated four times.

Test Plan:
- Reset release with BOOT_CYCLES=2 -> D_bub/E_bub/M_bub=1 for exactly 2 cycles, then RUN with all stall/bubble outputs 0, cyc_cnt starts 0.
- E_in_code=5, E_dst_m=3, d_src_a=3 -> F_st=D_st=E_bub=1, D_bub=0; stall_cnt and bub_cnt +1.
- E_in_code=7, e_cnd=0 -> D_bub=E_bub=1, F_st=0. E_in_code=5, E_dst_m=3, d_src_a=3 with D_in_code=9 -> D_st=1, D_bub=0.
- M_in_code=9, no lu -> F_st=1, D_bub=1. Sweep ret through D/E/M over 3 cycles -> 3 consecutive D_bub cycles.
- W_stat=HLT, W_in_code=0 at an edge -> next cycle halted=1, all stalls set, counters frozen. m_stat=ADR earlier -> M_bub=1, set_cc_en=0.
- W_stat=INS -> fault=1. Reset pulse mid-FAULT -> async return to BOOT, counters 0.
- CNT_W=4, run 20 cycles -> cyc_cnt holds 15.
